// File: rtl/sevenseg_scan_driver.sv
// ---------------------------------------------------------------------------
// sevenseg_scan_driver
//
// Purpose:
//   Multiplexed N-digit 7-segment driver for a common-anode display.
//   A packed word of nibbles is captured into a shadow register on a LOAD
//   strobe. A free-running scan visits one digit per REFRESH_DIV cycles. The
//   first GUARD cycles of every slot keep all anodes off so the previous
//   digit's segments cannot ghost onto the next digit. Each nibble is shown
//   as hex (MODE=0) or as a 4-bit two's complement value (MODE=1). In MODE=1
//   a negative nibble shows its magnitude with the decimal point lit.
//   Optional leading-zero blanking is available. Digit 0 is never blanked.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST        in   synchronous reset, active-high
//   LOAD       in   1-cycle strobe: capture DATA, MODE, BLANK_EN into shadow
//   MODE       in   0 = unsigned hex, 1 = per-nibble two's complement
//   BLANK_EN   in   1 = blank leading zero digits
//   DATA       in   nibble k drives digit k (digit 0 least significant)
//   SEG        out  {a,b,c,d,e,f,g}, active-low, registered
//   DP         out  decimal point, active-low, registered
//   AN         out  digit enables, active-low, at most one low, registered
//   DIGIT_TICK out  one-cycle pulse marking the start of each digit slot
//
// All outputs are registered from the pre-edge scan state and shadow
// contents, so they lag the internal state by one cycle.
// ---------------------------------------------------------------------------
module sevenseg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      LOAD,
  input  logic                      MODE,
  input  logic                      BLANK_EN,
  input  logic [4*NUM_DIGITS-1:0]   DATA,
  output logic [6:0]                SEG,
  output logic                      DP,
  output logic [NUM_DIGITS-1:0]     AN,
  output logic                      DIGIT_TICK
);

  // -------------------------------------------------------------------------
  // Derived widths and constants
  // -------------------------------------------------------------------------
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // -------------------------------------------------------------------------
  // Hex glyph table, active-low {a,b,c,d,e,f,g}
  // -------------------------------------------------------------------------
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0:    g = 7'b0000001;
      4'h1:    g = 7'b1001111;
      4'h2:    g = 7'b0010010;
      4'h3:    g = 7'b0000110;
      4'h4:    g = 7'b1001100;
      4'h5:    g = 7'b0100100;
      4'h6:    g = 7'b0100000;
      4'h7:    g = 7'b0001111;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0000100;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b1100000;
      4'hC:    g = 7'b0110001;
      4'hD:    g = 7'b1000010;
      4'hE:    g = 7'b0110000;
      default: g = 7'b0111000;  // F
    endcase
    return g;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] shadow_data_reg;
  logic                    shadow_mode_reg;
  logic                    shadow_blank_reg;

  logic [CNT_W-1:0]        cnt_reg,  cnt_next;
  logic [IDX_W-1:0]        idx_reg,  idx_next;

  logic [6:0]              seg_reg,  seg_next;
  logic                    dp_reg,   dp_next;
  logic [NUM_DIGITS-1:0]   an_reg,   an_next;
  logic                    tick_reg, tick_next;

  // -------------------------------------------------------------------------
  // Per-digit decode
  //
  // Every digit is decoded in parallel from the shadow. The scan index then
  // picks one. This keeps the decode independent of the scan position, so a
  // LOAD mid-slot shows up on the very next output update.
  // -------------------------------------------------------------------------
  logic [6:0] digit_seg [NUM_DIGITS];
  logic       digit_dp  [NUM_DIGITS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] nib;
      logic       neg;
      logic [3:0] mag;
      logic       upper_zero;
      logic       blank;

      assign nib = shadow_data_reg[4*gi +: 4];

      // In signed mode, nibbles 8..F are negative. Their magnitude is 16 - n,
      // which is 8 for 4'h8, so it still fits in four bits.
      assign neg = shadow_mode_reg & nib[3];
      assign mag = neg ? (4'd0 - nib) : nib;

      // This nibble and every nibble above it are zero.
      assign upper_zero = ((shadow_data_reg >> (4*gi)) == '0);

      if (gi == 0) begin : g_no_blank
        assign blank = 1'b0;
      end else begin : g_blank
        assign blank = shadow_blank_reg & upper_zero;
      end

      assign digit_seg[gi] = blank ? SEG_OFF : hex_glyph(mag);
      assign digit_dp[gi]  = blank ? 1'b1    : ~neg;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Scan counter next-state
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_next = cnt_reg;
    idx_next = idx_reg;
    if (cnt_reg == CNT_MAX) begin
      cnt_next = '0;
      idx_next = (idx_reg == IDX_MAX) ? '0 : idx_reg + 1'b1;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Output next-values, all taken from the pre-edge state
  // -------------------------------------------------------------------------
  logic guard_done;
  assign guard_done = (cnt_reg >= GUARD_C);

  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
      // Only the selected digit is driven low, and only after the guard band.
      assign an_next[gi] = ~(guard_done && (idx_reg == IDX_W'(gi)));
    end
  endgenerate

  always_comb begin
    seg_next = SEG_OFF;
    dp_next  = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_reg == IDX_W'(k)) begin
        seg_next = digit_seg[k];
        dp_next  = digit_dp[k];
      end
    end
  end

  // The tick is registered from the last count of a slot. It is therefore
  // high during the cycle in which the counter reads zero.
  assign tick_next = (cnt_reg == CNT_MAX);

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow_data_reg  <= '0;
      shadow_mode_reg  <= 1'b0;
      shadow_blank_reg <= 1'b0;
      cnt_reg          <= '0;
      idx_reg          <= '0;
      seg_reg          <= SEG_OFF;
      dp_reg           <= 1'b1;
      an_reg           <= '1;
      tick_reg         <= 1'b0;
    end else begin
      // LOAD touches only the shadow. The scan keeps running undisturbed.
      if (LOAD) begin
        shadow_data_reg  <= DATA;
        shadow_mode_reg  <= MODE;
        shadow_blank_reg <= BLANK_EN;
      end
      cnt_reg  <= cnt_next;
      idx_reg  <= idx_next;
      seg_reg  <= seg_next;
      dp_reg   <= dp_next;
      an_reg   <= an_next;
      tick_reg <= tick_next;
    end
  end

  assign SEG        = seg_reg;
  assign DP         = dp_reg;
  assign AN         = an_reg;
  assign DIGIT_TICK = tick_reg;

endmodule
